seq_mult_hs: RTL and testbench
==============================

// Module: seq_mult_hs
// PURPOSE
//  Iterative shift-add multiplier with valid/ready handshakes on both sides.
//  Successor to the free-running Mult block; adds signed/unsigned mode,
//  configurable bits-per-cycle and result hold under backpressure.
//  Sits between the DDS phase/amplitude logic and the output scaling stage,
//  trading latency for area on the tile.
// PARAMETERS
//  M    12  operand width in bits (>=2)
//  K    1   multiplier bits retired per cycle; must divide M; latency = M/K
// PORTS
//  clk          in   1    system clock, all state on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    operands a, b, signed_mode valid
//  in_ready     out  1    block can accept operands (high only in IDLE)
//  a            in   M    multiplicand
//  b            in   M    multiplier
//  signed_mode  in   1    1 = two's complement operands/result, 0 = unsigned
//  out_valid    out  1    mult holds a finished product
//  out_ready    in   1    consumer accepts product
//  mult         out  2M   product
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, mult=0,
//   counter=0, internal accumulators=0. Effective immediately; any operation
//   in flight is discarded, no partial result ever appears on mult.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. Edge with in_valid&in_ready: capture a, b, signed_mode;
//   in signed mode convert both to magnitudes (|-2^(M-1)| = 2^(M-1), held in
//   M unsigned bits) and record sign = a[M-1]^b[M-1]; clear accumulator;
//   counter=M/K; go RUN.
//  RUN: in_ready=0, in_valid ignored, operand inputs ignored. Each edge adds
//   (multiplicand * low K bits of multiplier) << (K*step) to a 2M-bit
//   accumulator, shifts multiplier right by K, decrements counter.
//   On the edge where counter goes 1->0: load mult with final product
//   (negated two's complement if sign=1 and signed mode), go DONE.
//  Latency: out_valid rises exactly M/K edges after the accepting edge
//   (M=12,K=1: 12; K=4: 3).
//  DONE: out_valid=1, mult stable. Edge with out_ready=1: out_valid=0, go
//   IDLE. out_ready=0: hold mult and out_valid indefinitely. in_ready=0 in
//   DONE, so one idle cycle separates consecutive products.
//  out_ready in IDLE/RUN has no effect. mult keeps the last product after
//   handoff until the next DONE overwrites it.
//  Width rules: unsigned product exact in 2M bits (max (2^M-1)^2).
//   Signed product exact in 2M bits incl. (-2^(M-1))^2 = 2^(2M-2); no
//   saturation or overflow case exists.
//  Zero operands take full latency (no early termination).
// TESTING
//  1 unsigned 5*5 (M=12,K=1) -> mult=25 (0x000019), out_valid 12 edges after
//    accept, in_ready low for those cycles.
//  2 unsigned 0xFFF*0xFFF -> 0xFFE001; signed 0xFFF*0xFFF (-1*-1) -> 0x000001.
//  3 signed 0x800*0x800 -> 0x400000; signed 0x800*0x001 -> 0xFFF800;
//    signed 0x7FF*0x800 -> 0xC00800.
//  4 backpressure: hold out_ready=0 for 20 cycles -> mult/out_valid stable;
//    in_valid pulses during RUN/DONE not accepted; out_ready=1 -> IDLE next edge.
//  5 rst_n low mid-RUN (cycle 6) -> out_valid=0, mult=0, in_ready=1 at once;
//    next 3*7 completes correctly (21).
//  6 K=4 build: 100 random signed/unsigned pairs vs reference model,
//    latency exactly 3 edges each.

Source files
------------

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier retiring K multiplier bits per cycle, with
// valid/ready handshakes on operands and product; signed mode works on magnitudes.
module seq_mult_hs #(
    parameter int M = 12,
    parameter int K = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] mult
);

    localparam int STEPS = M / K;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2*M-1:0]   r_mcand;
    logic [M-1:0]     r_mplier;
    logic [2*M-1:0]   r_acc;
    logic [2*M-1:0]   r_mult;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;

    logic [M-1:0]     w_mag_a;
    logic [M-1:0]     w_mag_b;
    logic [2*M-1:0]   w_partial;
    logic [2*M-1:0]   w_acc_next;
    logic [2*M-1:0]   w_final;

    // Magnitude of a two's complement value; the most negative value maps to 2^(M-1).
    function automatic logic [M-1:0] magnitude(input logic [M-1:0] v, input logic neg);
        magnitude = neg ? (~v + {{(M-1){1'b0}}, 1'b1}) : v;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next_state = S_RUN;
                else          w_next_state = S_IDLE;
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) w_next_state = S_DONE;
                else                 w_next_state = S_RUN;
            end
            S_DONE: begin
                if (out_ready) w_next_state = S_IDLE;
                else           w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand conditioning and one shift-add step of the datapath.
    always_comb begin
        w_mag_a    = magnitude(a, signed_mode & a[M-1]);
        w_mag_b    = magnitude(b, signed_mode & b[M-1]);
        w_partial  = r_mcand * {{(2*M-K){1'b0}}, r_mplier[K-1:0]};
        w_acc_next = r_acc + w_partial;
        if (r_sign) begin
            w_final = ~w_acc_next + (2*M)'(1);
        end else begin
            w_final = w_acc_next;
        end
    end

    // Datapath registers; mult only changes on the final RUN edge, so no partial sum leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mult   <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{M{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_sign   <= signed_mode & (a[M-1] ^ b[M-1]);
                        r_acc    <= '0;
                        r_cnt    <= CW'(STEPS);
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << K;
                    r_mplier <= r_mplier >> K;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_mult <= w_final;
                    end
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign mult      = r_mult;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed/table-driven bench: a K=1 and a K=4 instance share all inputs and
// are each checked for product, latency and handshake behaviour.
module tb_seq_mult_hs;

    localparam int M = 12;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [M-1:0]   a;
    logic [M-1:0]   b;
    logic           signed_mode;
    logic           out_ready;
    logic           in_ready1, out_valid1;
    logic           in_ready4, out_valid4;
    logic [2*M-1:0] mult1, mult4;

    int total = 0;
    int bad   = 0;

    seq_mult_hs #(.M(M), .K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid1),
        .out_ready(out_ready), .mult(mult1)
    );

    seq_mult_hs #(.M(M), .K(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .mult(mult4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0]   a;
        logic [M-1:0]   b;
        logic           sm;
        logic [2*M-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*M-1:0] ref_mult(input logic [M-1:0] x, input logic [M-1:0] y,
                                                input logic sm);
        longint sx, sy, p;
        logic [63:0] pv;
        sx = longint'(x);
        sy = longint'(y);
        if (sm && x[M-1]) sx = sx - 4096;
        if (sm && y[M-1]) sy = sy - 4096;
        p  = sx * sy;
        pv = p;
        return pv[2*M-1:0];
    endfunction

    // Accepts one operand pair on both instances and waits for both products.
    task automatic start_and_wait(input logic [M-1:0] xa, input logic [M-1:0] xb,
                                  input logic sm, input logic [2*M-1:0] exp, input string name);
        int lat1, lat4;
        bit busy_ready;
        @(negedge clk);
        chk({name, " in_ready before accept"}, {62'd0, in_ready1, in_ready4}, 64'd3);
        a = xa; b = xb; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat1 = 0; lat4 = 0; busy_ready = 1'b0;
        for (int n = 1; n <= 40 && lat1 == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = (n == 2 || n == 5 || n == 11);
            a = 12'($urandom); b = 12'($urandom); signed_mode = 1'($urandom);
            if (out_valid1 && lat1 == 0) lat1 = n;
            if (out_valid4 && lat4 == 0) lat4 = n;
            if (!out_valid1 && in_ready1) busy_ready = 1'b1;
            if (in_ready4) busy_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk({name, " latency K=1"}, 64'(lat1), 64'd12);
        chk({name, " latency K=4"}, 64'(lat4), 64'd3);
        chk({name, " in_ready busy"}, {63'd0, busy_ready}, 64'd0);
        chk({name, " mult K=1"}, 64'(mult1), 64'(exp));
        chk({name, " mult K=4"}, 64'(mult4), 64'(exp));
    endtask

    // Releases the held product and checks return to IDLE with mult retained.
    task automatic handoff(input logic [2*M-1:0] exp, input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " after handoff"}, {60'd0, out_valid1, out_valid4, in_ready1, in_ready4}, 64'd3);
        chk({name, " mult retained"}, {16'd0, mult1, mult4}, {16'd0, exp, exp});
    endtask

    initial begin
        bit hold_bad;
        logic [M-1:0]   ra, rb;
        logic           rs;
        logic [2*M-1:0] rexp;

        vecs[0]  = '{12'h005, 12'h005, 1'b0, 24'h000019};
        vecs[1]  = '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001};
        vecs[2]  = '{12'hFFF, 12'hFFF, 1'b1, 24'h000001};
        vecs[3]  = '{12'h800, 12'h800, 1'b1, 24'h400000};
        vecs[4]  = '{12'h800, 12'h001, 1'b1, 24'hFFF800};
        vecs[5]  = '{12'h7FF, 12'h800, 1'b1, 24'hC00800};
        vecs[6]  = '{12'h000, 12'hABC, 1'b0, 24'h000000};
        vecs[7]  = '{12'hFFF, 12'h002, 1'b1, 24'hFFFFFE};
        vecs[8]  = '{12'h800, 12'h800, 1'b0, 24'h400000};
        vecs[9]  = '{12'h7FF, 12'h7FF, 1'b1, 24'h3FF001};
        vecs[10] = '{12'h003, 12'h007, 1'b1, 24'h000015};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 12'h000; b = 12'h000; signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset state", {12'd0, in_ready1, out_valid1, mult1, in_ready4, out_valid4, mult4},
            {12'd0, 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0});
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start_and_wait(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));
            handoff(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: product and out_valid held while junk operands are offered.
        start_and_wait(12'h123, 12'h045, 1'b0, 24'h004E6F, "bp");
        hold_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 12'($urandom); b = 12'($urandom);
            if (!out_valid1 || !out_valid4 || in_ready1 || in_ready4) hold_bad = 1'b1;
            if (mult1 !== 24'h004E6F || mult4 !== 24'h004E6F) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp hold stable", {63'd0, hold_bad}, 64'd0);
        handoff(24'h004E6F, "bp");

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 12'h0AB; b = 12'h0CD; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-run reset", {12'd0, in_ready1, out_valid1, mult1, in_ready4, out_valid4, mult4},
            {12'd0, 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0});
        @(negedge clk);
        rst_n = 1'b1;
        start_and_wait(12'h003, 12'h007, 1'b0, 24'h000015, "post-reset");
        handoff(24'h000015, "post-reset");

        // Random pairs against the reference model.
        for (int r = 0; r < 100; r++) begin
            ra = 12'($urandom); rb = 12'($urandom); rs = 1'($urandom);
            rexp = ref_mult(ra, rb, rs);
            start_and_wait(ra, rb, rs, rexp, $sformatf("rnd%0d", r));
            handoff(rexp, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
